// File: rtl/lfsr_rand_gen.sv
// XNOR Fibonacci LFSR with seed load, free-run stepping and a req/valid draw port
// that returns a value in [0, RANGE) by bounded rejection sampling.
module lfsr_rand_gen #(
  parameter int unsigned      WIDTH     = 10,
  parameter logic [WIDTH-1:0] TAPS      = 10'b0000001001,
  parameter logic [WIDTH-1:0] SEED      = '0,
  parameter int unsigned      RANGE     = 10,
  parameter int unsigned      OUT_W     = $clog2(RANGE),
  parameter int unsigned      MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_out,
  output logic             seed_err,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic             fallback
);

  localparam int unsigned      TRIES_W   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);
  // One extra bit so a power-of-two RANGE still compares correctly.
  localparam logic [OUT_W:0]   RANGE_EXT = (OUT_W + 1)'(RANGE);
  localparam logic [WIDTH-1:0] ALL_ONES  = '1;

  typedef enum logic {StIdle, StDraw} state_e;

  state_e             fsm_q, fsm_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_next;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic [OUT_W-1:0]   value_q, value_d, cand;
  logic               valid_q, valid_d;
  logic               fallback_q, fallback_d;
  logic               seed_err_q, seed_err_d;
  logic               cand_ok, last_try;

  assign lfsr_next = {~^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};
  assign cand      = lfsr_next[OUT_W-1:0];
  assign cand_ok   = {1'b0, cand} < RANGE_EXT;
  assign last_try  = (tries_q == LAST_TRY);

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= StIdle;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next state; seed_load always wins and aborts any draw in flight
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle: if (!seed_load && req) fsm_d = StDraw;
      StDraw: if (seed_load || cand_ok || last_try) fsm_d = StIdle;
    endcase
  end

  // Datapath next state
  always_comb begin
    lfsr_d     = lfsr_q;
    tries_d    = tries_q;
    value_d    = value_q;
    fallback_d = fallback_q;
    valid_d    = 1'b0;
    seed_err_d = 1'b0;
    if (seed_load) begin
      if (seed_in == ALL_ONES) begin
        lfsr_d     = SEED;
        seed_err_d = 1'b1;
      end else begin
        lfsr_d = seed_in;
      end
      tries_d = '0;
    end else if (fsm_q == StDraw) begin
      lfsr_d = lfsr_next;
      if (cand_ok) begin
        value_d    = cand;
        fallback_d = 1'b0;
        valid_d    = 1'b1;
        tries_d    = '0;
      end else if (last_try) begin
        // 2**OUT_W < 2*RANGE, so one subtraction lands inside the range
        value_d    = OUT_W'({1'b0, cand} - RANGE_EXT);
        fallback_d = 1'b1;
        valid_d    = 1'b1;
        tries_d    = '0;
      end else begin
        tries_d = tries_q + TRIES_W'(1);
      end
    end else if (req) begin
      tries_d = '0;
    end else if (en) begin
      lfsr_d = lfsr_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q     <= SEED;
      tries_q    <= '0;
      value_q    <= '0;
      fallback_q <= 1'b0;
      valid_q    <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      tries_q    <= tries_d;
      value_q    <= value_d;
      fallback_q <= fallback_d;
      valid_q    <= valid_d;
      seed_err_q <= seed_err_d;
    end
  end

  // Outputs
  always_comb begin
    busy      = (fsm_q == StDraw);
    state_out = lfsr_q;
    valid     = valid_q;
    value     = value_q;
    fallback  = fallback_q;
    seed_err  = seed_err_q;
  end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Bench for lfsr_rand_gen: transaction-level draw model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_lfsr_rand_gen;

  localparam logic [9:0] TAPS = 10'b0000001001;

  logic       clk, reset, en, seed_load, req, req2;
  logic [9:0] seed_in;
  logic [9:0] state_out, state_out2;
  logic       seed_err, seed_err2, busy, busy2, valid, valid2, fallback, fallback2;
  logic [3:0] value, value2;

  lfsr_rand_gen dut (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .state_out(state_out), .seed_err(seed_err), .req(req), .busy(busy),
    .valid(valid), .value(value), .fallback(fallback)
  );

  lfsr_rand_gen #(.MAX_TRIES(1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .state_out(state_out2), .seed_err(seed_err2), .req(req2), .busy(busy2),
    .valid(valid2), .value(value2), .fallback(fallback2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Next state: feedback is 1 when an even number of tapped bits are set.
  function automatic logic [9:0] step(input logic [9:0] s);
    logic [9:0] fb;
    fb = ($countones(s & TAPS) % 2 == 0) ? 10'd1 : 10'd0;
    return (s >> 1) | (fb << 9);
  endfunction

  // Model (MAX_TRIES=8, RANGE=10): a draw is planned in full when accepted.
  logic [9:0] m_state;
  logic       m_busy, m_valid, m_fb, m_serr, m_res_fb;
  logic [3:0] m_value, m_res;
  logic [9:0] m_q[$];

  task automatic plan_draw(input logic [9:0] start);
    logic [9:0] s;
    int c;
    s = start;
    for (int t = 0; t < 8; t++) begin
      s = step(s);
      m_q.push_back(s);
      c = int'(s) % 16;
      if (c < 10) begin
        m_res = 4'(c); m_res_fb = 1'b0;
        break;
      end
      if (t == 7) begin
        m_res = 4'(c - 10); m_res_fb = 1'b1;
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_state = 10'h000; m_busy = 0; m_valid = 0; m_value = 0; m_fb = 0; m_serr = 0;
      m_q.delete();
    end else begin
      m_valid = 0; m_serr = 0;
      if (seed_load) begin
        if (seed_in == 10'h3FF) begin m_state = 10'h000; m_serr = 1; end
        else m_state = seed_in;
        m_busy = 0; m_q.delete();
      end else if (m_busy) begin
        m_state = m_q.pop_front();
        if (m_q.size() == 0) begin
          m_busy = 0; m_valid = 1; m_value = m_res; m_fb = m_res_fb;
        end
      end else if (req) begin
        plan_draw(m_state); m_busy = 1;
      end else if (en) begin
        m_state = step(m_state);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_state", 32'(state_out), 32'(m_state));
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_valid", 32'(valid), 32'(m_valid));
      chk("m_value", 32'(value), 32'(m_value));
      chk("m_fallback", 32'(fallback), 32'(m_fb));
      chk("m_seed_err", 32'(seed_err), 32'(m_serr));
    end
  end

  bit seen[1024];
  int bad;
  logic [9:0] t1_exp[3];

  initial begin
    reset = 0; en = 0; seed_load = 0; seed_in = '0; req = 0; req2 = 0;
    @(posedge clk);
    chk_on = 1;
    @(negedge clk);
    chk("rst_state", 32'(state_out), 32'h000);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_value", 32'(value), 0);
    reset = 1;

    // T1
    t1_exp[0] = 10'h200; t1_exp[1] = 10'h300; t1_exp[2] = 10'h380;
    en = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_step", 32'(state_out), 32'(t1_exp[i]));
    end
    en = 0; seed_load = 1; seed_in = 10'h000;

    // T2
    @(negedge clk);
    seed_load = 0; en = 1;
    bad = 0;
    seen[0] = 1;
    for (int i = 1; i <= 1023; i++) begin
      @(negedge clk);
      if (i < 1023) begin
        if (seen[state_out] || state_out == 10'h3FF) bad++;
        seen[state_out] = 1;
      end
    end
    en = 0;
    chk("t2_return", 32'(state_out), 32'h000);
    chk("t2_no_repeat", 32'(bad), 0);

    // T3 and back-to-back
    req = 1;
    @(negedge clk);
    req = 0;
    chk("t3_busy", 32'(busy), 1);
    @(negedge clk);
    chk("t3_valid", 32'(valid), 1);
    chk("t3_value", 32'(value), 0);
    chk("t3_fallback", 32'(fallback), 0);
    chk("t3_state", 32'(state_out), 32'h200);
    req = 1;
    @(negedge clk);
    req = 0;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_no_dbl_valid", 32'(valid), 0);
    @(negedge clk);
    chk("b2b_valid", 32'(valid), 1);
    chk("b2b_state", 32'(state_out), 32'h300);

    // T4 (MAX_TRIES=8) and T5 (MAX_TRIES=1) from the same seed
    seed_load = 1; seed_in = 10'h01E;
    @(negedge clk);
    seed_load = 0; req = 1; req2 = 1;
    @(negedge clk);
    req = 0; req2 = 0;
    chk("t4_busy", 32'(busy), 1);
    chk("t5_busy", 32'(busy2), 1);
    @(negedge clk);
    chk("t4_reject_state", 32'(state_out), 32'h00F);
    chk("t4_no_valid", 32'(valid), 0);
    chk("t5_valid", 32'(valid2), 1);
    chk("t5_value", 32'(value2), 5);
    chk("t5_fallback", 32'(fallback2), 1);
    chk("t5_idle", 32'(busy2), 0);
    @(negedge clk);
    chk("t4_valid", 32'(valid), 1);
    chk("t4_value", 32'(value), 7);
    chk("t4_fallback", 32'(fallback), 0);
    chk("t4_state", 32'(state_out), 32'h207);
    chk("t5_pulse", 32'(valid2), 0);

    // seed_load aborts a draw
    seed_load = 1; seed_in = 10'h01E;
    @(negedge clk);
    seed_load = 0; req = 1;
    @(negedge clk);
    req = 0; seed_load = 1; seed_in = 10'h100;
    @(negedge clk);
    seed_load = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_state", 32'(state_out), 32'h100);
    @(negedge clk);
    chk("abort_no_valid", 32'(valid), 0);

    // T6: all-ones seed rejected
    seed_load = 1; seed_in = 10'h3FF;
    @(negedge clk);
    seed_load = 0;
    chk("t6_seed_err", 32'(seed_err), 1);
    chk("t6_seed_state", 32'(state_out), 32'h000);
    @(negedge clk);
    chk("t6_seed_err_pulse", 32'(seed_err), 0);

    // T6: reset mid-draw
    seed_load = 1; seed_in = 10'h01E;
    @(negedge clk);
    seed_load = 0; req = 1;
    @(negedge clk);
    req = 0;
    #2 reset = 0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_state", 32'(state_out), 32'h000);
    chk("t6_rst_valid", 32'(valid), 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("t6_rst_no_valid", 32'(valid), 0);

    // Mixed free-run and draws, model-checked
    for (int i = 0; i < 40; i++) begin
      en  = (i % 3) != 0;
      req = (i % 7) == 2;
      @(negedge clk);
    end
    en = 0; req = 0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
